rsc2_enc_punct_pack: RTL and testbench

//  Joint puncture-and-pack stage for the rsc2 duobinary encoder. Per input symbol it

---
 rtl/rsc2_enc_punct_pack.sv | 235 +++++++++++++++++++++++
 tb/tb_rsc2_enc_punct_pack.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rsc2_enc_punct_pack.sv
// Puncture-and-pack stage for the rsc2 duobinary encoder: drops parity per coderate,
// packs surviving bits LSB-first into pODAT_W-bit words with ready/valid on both sides.
module rsc2_enc_punct_pack #(
  parameter int pODAT_W = 8,
  parameter bit pW_EN   = 1'b1
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic [2:0]         icode,
  input  logic               isop,
  input  logic               ieop,
  input  logic               ival,
  input  logic [1:0]         iab,
  input  logic [1:0]         iy,
  input  logic [1:0]         iw,
  output logic               ordy,
  input  logic               irdy,
  output logic               oval,
  output logic [pODAT_W-1:0] odat,
  output logic               osop,
  output logic               oeop,
  output logic [5:0]         onbits,
  output logic               oerr
);

  localparam int         ACC_W  = pODAT_W + 6;
  localparam logic [5:0] WORD_N = 6'(pODAT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Last phase index of the puncture period for each coderate.
  function automatic logic [4:0] punct_period(input logic [2:0] code);
    logic [4:0] p;
    case (code)
      3'd0:    p = 5'd0;
      3'd1:    p = 5'd0;
      3'd2:    p = 5'd1;
      3'd3:    p = 5'd5;
      3'd4:    p = 5'd3;
      3'd5:    p = 5'd19;
      3'd6:    p = 5'd11;
      3'd7:    p = 5'd27;
      default: p = 5'd0;
    endcase
    return p;
  endfunction

  function automatic logic [27:0] punct_ymask(input logic [2:0] code);
    logic [27:0] m;
    case (code)
      3'd0:    m = 28'h000_0001;
      3'd1:    m = 28'h000_0001;
      3'd2:    m = 28'h000_0001;
      3'd3:    m = 28'h000_0005;
      3'd4:    m = 28'h000_0001;
      3'd5:    m = 28'h000_1111;
      3'd6:    m = 28'h000_0011;
      3'd7:    m = 28'h101_0111;
      default: m = 28'h000_0001;
    endcase
    return m;
  endfunction

  function automatic logic [27:0] punct_wmask(input logic [2:0] code);
    logic [27:0] m;
    case (code)
      3'd0:    m = 28'h000_0001;
      default: m = 28'h000_0000;
    endcase
    return m;
  endfunction

  state_t               state_r, state_nxt_s;
  logic [2:0]           code_r, cur_code_s;
  logic [4:0]           phase_r, cur_phase_s, phase_nxt_s;
  logic [ACC_W-1:0]     acc_r, base_acc_s, acc_nxt_s;
  logic [5:0]           fill_r, base_fill_s, fill_nxt_s, emit_cnt_s;
  logic                 sop_pend_r;
  logic                 ordy_r, ordy_nxt_s;
  logic                 oval_r, osop_r, oeop_r, oerr_r;
  logic [pODAT_W-1:0]   odat_r;
  logic [5:0]           onbits_r;
  logic                 accept_s, start_s, keep_s;
  logic [27:0]          ymask_s, wmask_s;
  logic                 y_en_s, w_en_s;
  logic [5:0]           app_bits_s, app_cnt_s;
  logic                 can_load_s, full_s, resid_s, load_full_s, load_res_s;

  assign ordy   = ordy_r;
  assign oval   = oval_r;
  assign odat   = odat_r;
  assign osop   = osop_r;
  assign oeop   = oeop_r;
  assign onbits = onbits_r;
  assign oerr   = oerr_r;

  // Next-state datapath: puncture selection, accumulator append/shift, FSM.
  always_comb begin
    accept_s    = ival & ordy_r & iclkena;
    start_s     = accept_s & isop;
    cur_code_s  = start_s ? icode : code_r;
    cur_phase_s = start_s ? 5'd0 : phase_r;
    ymask_s     = punct_ymask(cur_code_s);
    wmask_s     = punct_wmask(cur_code_s);
    y_en_s      = ymask_s[cur_phase_s];
    w_en_s      = pW_EN & wmask_s[cur_phase_s];

    case ({y_en_s, w_en_s})
      2'b11: begin app_bits_s = {iw, iy, iab};   app_cnt_s = 6'd6; end
      2'b10: begin app_bits_s = {2'b00, iy, iab}; app_cnt_s = 6'd4; end
      2'b01: begin app_bits_s = {2'b00, iw, iab}; app_cnt_s = 6'd4; end
      default: begin app_bits_s = {4'b0000, iab}; app_cnt_s = 6'd2; end
    endcase

    // Symbols outside a frame (IDLE without isop) are accepted but not appended.
    keep_s = accept_s & (start_s | (state_r == RUN));

    can_load_s  = iclkena & (~oval_r | irdy);
    full_s      = (fill_r >= WORD_N);
    resid_s     = (state_r == FLUSH) & (fill_r != 6'd0) & ~full_s;
    load_full_s = can_load_s & full_s;
    load_res_s  = can_load_s & resid_s;

    if (load_full_s) begin
      emit_cnt_s = WORD_N;
    end else if (load_res_s) begin
      emit_cnt_s = fill_r;
    end else begin
      emit_cnt_s = 6'd0;
    end

    if (start_s) begin
      base_acc_s  = '0;
      base_fill_s = 6'd0;
    end else begin
      base_acc_s  = acc_r >> emit_cnt_s;
      base_fill_s = fill_r - emit_cnt_s;
    end

    if (keep_s) begin
      acc_nxt_s   = base_acc_s | (ACC_W'(app_bits_s) << base_fill_s);
      fill_nxt_s  = base_fill_s + app_cnt_s;
      phase_nxt_s = (cur_phase_s == punct_period(cur_code_s)) ? 5'd0 : cur_phase_s + 5'd1;
    end else begin
      acc_nxt_s   = base_acc_s;
      fill_nxt_s  = base_fill_s;
      phase_nxt_s = phase_r;
    end

    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = ieop ? FLUSH : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s & ieop) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (iclkena & oval_r & oeop_r & irdy) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: state_nxt_s = IDLE;
    endcase

    ordy_nxt_s = (state_nxt_s != FLUSH) & (fill_nxt_s < WORD_N);
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_r    <= IDLE;
      code_r     <= 3'd0;
      phase_r    <= 5'd0;
      acc_r      <= '0;
      fill_r     <= 6'd0;
      sop_pend_r <= 1'b0;
      ordy_r     <= 1'b0;
      oval_r     <= 1'b0;
      odat_r     <= '0;
      osop_r     <= 1'b0;
      oeop_r     <= 1'b0;
      onbits_r   <= 6'd0;
      oerr_r     <= 1'b0;
    end else if (iclkena) begin
      state_r <= state_nxt_s;
      code_r  <= cur_code_s;
      phase_r <= phase_nxt_s;
      acc_r   <= acc_nxt_s;
      fill_r  <= fill_nxt_s;
      ordy_r  <= ordy_nxt_s;
      oerr_r  <= start_s & (state_r == RUN);

      if (start_s) begin
        sop_pend_r <= 1'b1;
      end else if (load_full_s | load_res_s) begin
        sop_pend_r <= 1'b0;
      end else begin
        sop_pend_r <= sop_pend_r;
      end

      // A full word ending exactly at frame end carries oeop itself.
      if (load_full_s | load_res_s) begin
        oval_r   <= 1'b1;
        odat_r   <= acc_r[pODAT_W-1:0];
        osop_r   <= sop_pend_r;
        oeop_r   <= load_res_s | ((state_r == FLUSH) & (fill_r == WORD_N));
        onbits_r <= load_full_s ? WORD_N : fill_r;
      end else if (irdy) begin
        oval_r <= 1'b0;
        osop_r <= 1'b0;
        oeop_r <= 1'b0;
      end else begin
        oval_r <= oval_r;
      end
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_rsc2_enc_punct_pack.sv
// Directed bench for rsc2_enc_punct_pack: table of frames with hand-computed words,
// plus sequences for backpressure, double isop, clock-enable hold and mid-flush reset.
module tb_rsc2_enc_punct_pack;

  logic       iclk = 1'b0;
  logic       ireset, iclkena, isop, ieop, ival, irdy;
  logic [2:0] icode;
  logic [1:0] iab, iy, iw;
  logic       ordy, oval, osop, oeop, oerr;
  logic [7:0] odat;
  logic [5:0] onbits;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [5:0] nb;
  } word_t;

  typedef struct {
    logic [2:0]  code;
    int          n;
    logic [1:0]  ab;
    logic [1:0]  y;
    logic [1:0]  w;
    int          nw;
    logic [31:0] words;
    logic [5:0]  last_nb;
  } vec_t;

  word_t q[$];
  vec_t  vt[7];

  rsc2_enc_punct_pack #(.pODAT_W(8), .pW_EN(1'b1)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .icode(icode),
    .isop(isop), .ieop(ieop), .ival(ival), .iab(iab), .iy(iy), .iw(iw),
    .ordy(ordy), .irdy(irdy), .oval(oval), .odat(odat), .osop(osop),
    .oeop(oeop), .onbits(onbits), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  // Words handed over at the next rising edge.
  always @(negedge iclk) begin
    if (!ireset && iclkena && oval && irdy) q.push_back({odat, osop, oeop, onbits});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_sym(input logic sop, input logic eop, input logic [2:0] code,
                          input logic [1:0] ab, input logic [1:0] y, input logic [1:0] w);
    bit done;
    done = 1'b0;
    isop = sop; ieop = eop; icode = code; iab = ab; iy = y; iw = w; ival = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge iclk);
      if (ordy) done = 1'b1;
      @(posedge iclk);
      #1;
    end
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    check("sym_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic expect_frame(input string name, input int nw, input logic [31:0] words,
                              input logic [5:0] last_nb);
    bit          seen;
    logic [31:0] tmp;
    seen = (q.size() > 0) && q[q.size()-1].eop;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge iclk);
      #1;
      seen = (q.size() > 0) && q[q.size()-1].eop;
    end
    check({name, "_eop_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_nwords"}, q.size(), nw);
    for (int i = 0; i < q.size() && i < nw; i++) begin
      tmp = words >> (8 * i);
      check({name, "_data"}, {24'd0, q[i].d}, {24'd0, tmp[7:0]});
      check({name, "_onbits"}, {26'd0, q[i].nb}, (i == nw - 1) ? {26'd0, last_nb} : 32'd8);
      check({name, "_osop"}, {31'd0, q[i].sop}, (i == 0) ? 32'd1 : 32'd0);
      check({name, "_oeop"}, {31'd0, q[i].eop}, (i == nw - 1) ? 32'd1 : 32'd0);
    end
    q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // code, symbols, ab, y, w, words, packed words (word0 in [7:0]), last onbits
    vt[0] = '{3'd1, 4, 2'b01, 2'b10, 2'b00, 2, 32'h0000_9999, 6'd8};
    vt[1] = '{3'd2, 4, 2'b11, 2'b11, 2'b00, 2, 32'h0000_0FFF, 6'd4};
    vt[2] = '{3'd0, 4, 2'b01, 2'b00, 2'b11, 3, 32'h00C7_1C71, 6'd8};
    vt[3] = '{3'd3, 4, 2'b10, 2'b01, 2'b00, 2, 32'h0000_09A6, 6'd4};
    vt[4] = '{3'd4, 5, 2'b11, 2'b00, 2'b00, 2, 32'h0000_0FF3, 6'd6};
    vt[5] = '{3'd7, 1, 2'b10, 2'b11, 2'b00, 1, 32'h0000_000E, 6'd4};
    vt[6] = '{3'd5, 6, 2'b00, 2'b11, 2'b00, 2, 32'h0000_300C, 6'd8};

    ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0; irdy = 1'b1;
    icode = 3'd0; iab = 2'b00; iy = 2'b00; iw = 2'b00;
    repeat (3) @(posedge iclk);
    #1;
    check("rst_oval", {31'd0, oval}, 32'd0);
    check("rst_ordy", {31'd0, ordy}, 32'd0);
    check("rst_oerr", {31'd0, oerr}, 32'd0);
    check("rst_odat", {24'd0, odat}, 32'd0);
    check("rst_onbits", {26'd0, onbits}, 32'd0);
    check("rst_flags", {30'd0, osop, oeop}, 32'd0);
    ireset = 1'b0;
    @(posedge iclk);
    #1;
    check("ordy_after_reset", {31'd0, ordy}, 32'd1);

    // Table frames; icode is scrambled after isop to show the code is latched.
    for (int v = 0; v < 7; v++) begin
      for (int s = 0; s < vt[v].n; s++) begin
        send_sym(s == 0, s == vt[v].n - 1, (s == 0) ? vt[v].code : (vt[v].code ^ 3'd5),
                 vt[v].ab, vt[v].y, vt[v].w);
      end
      expect_frame($sformatf("vec%0d", v), vt[v].nw, vt[v].words, vt[v].last_nb);
    end

    // isop accepted in RUN: oerr pulse, earlier bits discarded.
    send_sym(1'b1, 1'b0, 3'd1, 2'b11, 2'b11, 2'b00);
    send_sym(1'b1, 1'b0, 3'd1, 2'b01, 2'b10, 2'b00);
    check("oerr_pulse", {31'd0, oerr}, 32'd1);
    @(posedge iclk);
    #1;
    check("oerr_clear", {31'd0, oerr}, 32'd0);
    send_sym(1'b0, 1'b1, 3'd3, 2'b01, 2'b10, 2'b00);
    expect_frame("dbl_sop", 1, 32'h0000_0099, 6'd8);

    // Backpressure: held word stays put, ordy drops, nothing lost.
    send_sym(1'b1, 1'b0, 3'd1, 2'b01, 2'b10, 2'b00);
    send_sym(1'b0, 1'b0, 3'd4, 2'b01, 2'b10, 2'b00);
    irdy = 1'b0;
    send_sym(1'b0, 1'b0, 3'd4, 2'b01, 2'b10, 2'b00);
    send_sym(1'b0, 1'b0, 3'd4, 2'b01, 2'b10, 2'b00);
    for (int c = 0; c < 10; c++) begin
      @(posedge iclk);
      #1;
      check("stall_oval", {31'd0, oval}, 32'd1);
      check("stall_odat", {24'd0, odat}, 32'h99);
      check("stall_ordy", {31'd0, ordy}, 32'd0);
    end
    iclkena = 1'b0;
    irdy = 1'b1;
    repeat (3) begin
      @(posedge iclk);
      #1;
      check("clkena_hold_oval", {31'd0, oval}, 32'd1);
      check("clkena_hold_ordy", {31'd0, ordy}, 32'd0);
    end
    check("clkena_no_take", q.size(), 0);
    iclkena = 1'b1;
    for (int s = 4; s < 8; s++) send_sym(1'b0, s == 7, 3'd4, 2'b01, 2'b10, 2'b00);
    expect_frame("backpressure", 4, 32'h9999_9999, 6'd8);

    // Reset while the final word waits in FLUSH; next frame packs from bit 0.
    irdy = 1'b0;
    send_sym(1'b1, 1'b0, 3'd1, 2'b01, 2'b10, 2'b00);
    send_sym(1'b0, 1'b1, 3'd1, 2'b11, 2'b10, 2'b00);
    @(posedge iclk);
    #1;
    check("flush_word_held", {31'd0, oval}, 32'd1);
    ireset = 1'b1;
    @(posedge iclk);
    #1;
    check("midflush_rst_oval", {31'd0, oval}, 32'd0);
    check("midflush_rst_ordy", {31'd0, ordy}, 32'd0);
    q.delete();
    ireset = 1'b0;
    irdy = 1'b1;
    send_sym(1'b1, 1'b1, 3'd2, 2'b11, 2'b01, 2'b00);
    expect_frame("after_reset", 1, 32'h0000_0007, 6'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
